// File: rtl/glb_write_pkg.sv
// Shared types and width helpers for the GLB-side block streamer.
package glb_write_pkg;

    // Transmit FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_HDR   = 3'd2,
        ST_PAY   = 3'd3,
        ST_FIN   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Default geometry
    localparam int DEF_NUM_BLOCKS = 1;
    localparam int DEF_DEPTH      = 1024;
    localparam int DEF_DATA_WIDTH = 16;

    // At most two blocks, so a single bit selects the block
    localparam int BLK_W = 1;

    // Payload address width (kept at least one bit wide)
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Word counter / size width: must be able to hold the value DEPTH itself
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEF_ADDR_W = addr_w(DEF_DEPTH);
    localparam int DEF_CNT_W  = cnt_w(DEF_DEPTH);

endpackage

// File: rtl/glb_write_if.sv
// Ready/valid stream link from the GLB writer towards the IO tile.
interface glb_write_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  done;

    // Source side: drives the stream and the done flag
    modport master (
        output data,
        output valid,
        output done,
        input  ready
    );

    // Sink side: consumes the stream and applies backpressure
    modport slave (
        input  data,
        input  valid,
        input  done,
        output ready
    );
endinterface

// File: rtl/glb_write_buf.sv
// Block buffers and block length registers for the GLB writer.
// One write port from the load bus, one combinational read port.
module glb_write_buf
    import glb_write_pkg::*;
#(
    parameter  int NUM_BLOCKS = DEF_NUM_BLOCKS,
    parameter  int DEPTH      = DEF_DEPTH,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int ADDR_W     = addr_w(DEPTH),
    localparam int CNT_W      = cnt_w(DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_en_i,
    input  logic [BLK_W-1:0]                      wr_blk_i,
    input  logic [ADDR_W-1:0]                     wr_addr_i,
    input  logic [DATA_WIDTH-1:0]                 wr_data_i,
    input  logic                                  size_en_i,
    input  logic [DATA_WIDTH-1:0]                 size_i,
    input  logic [BLK_W-1:0]                      rd_blk_i,
    input  logic [ADDR_W-1:0]                     rd_addr_i,
    output logic [DATA_WIDTH-1:0]                 rd_data_o,
    output logic [NUM_BLOCKS-1:0][CNT_W-1:0]      sizes_o
);

    // Lengths above DEPTH are stored as DEPTH so the reader never wraps
    function automatic logic [CNT_W-1:0] clamp_size(input logic [DATA_WIDTH-1:0] sz);
        logic [63:0] wide;
        wide = 64'(sz);
        if (wide > 64'(DEPTH)) begin
            return CNT_W'(DEPTH);
        end else begin
            return CNT_W'(sz);
        end
    endfunction

    logic [NUM_BLOCKS-1:0][DATA_WIDTH-1:0] rd_word_s;

    for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_blk
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [CNT_W-1:0]      size_q;

        // Payload storage write; contents survive reset
        always_ff @(posedge clk) begin
            if (wr_en_i && (wr_blk_i == BLK_W'(b))) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
        end

        // Block length register, cleared by reset, clamped on write
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                size_q <= {CNT_W{1'b0}};
            end else if (size_en_i && (wr_blk_i == BLK_W'(b))) begin
                size_q <= clamp_size(size_i);
            end
        end

        assign rd_word_s[b] = mem_q[rd_addr_i];
        assign sizes_o[b]   = size_q;
    end

    // Select the addressed block's word
    always_comb begin
        rd_data_o = rd_word_s[0];
        if ((NUM_BLOCKS > 1) && (rd_blk_i == BLK_W'(1))) begin
            rd_data_o = rd_word_s[NUM_BLOCKS-1];
        end else begin
            rd_data_o = rd_word_s[0];
        end
    end

endmodule

// File: rtl/glb_write.sv
// GLB-side block streamer: after a flush pulse sends every block as
// a length header followed by its payload over a registered ready/valid link.
module glb_write
    import glb_write_pkg::*;
#(
    parameter  int NUM_BLOCKS = DEF_NUM_BLOCKS,
    parameter  int DEPTH      = DEF_DEPTH,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int ADDR_W     = addr_w(DEPTH),
    localparam int CNT_W      = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  ld_en_i,
    input  logic                  ld_blk_i,
    input  logic [ADDR_W-1:0]     ld_addr_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i,
    input  logic                  ld_size_en_i,
    input  logic [DATA_WIDTH-1:0] ld_size_i,
    glb_write_if.master           strm
);

    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLOCKS - 1);

    // Header word: size zero-extended or truncated to the word width
    function automatic logic [DATA_WIDTH-1:0] hdr_word(input logic [CNT_W-1:0] sz);
        logic [DATA_WIDTH+CNT_W-1:0] wide;
        wide = {{DATA_WIDTH{1'b0}}, sz};
        return wide[DATA_WIDTH-1:0];
    endfunction

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BLK_W-1:0]        blk_q, blk_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;

    logic [NUM_BLOCKS-1:0][CNT_W-1:0] sizes_s;
    logic [DATA_WIDTH-1:0]   rd_data_s;
    logic [ADDR_W-1:0]       rd_addr_s;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic [CNT_W-1:0]        cur_size_s;
    logic                    last_word_s;
    logic                    ld_ok_s;

    // Loads are only accepted while no stream is in flight
    assign ld_ok_s = (state_q == ST_IDLE) || (state_q == ST_DONE);

    glb_write_buf #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (ld_en_i && ld_ok_s),
        .wr_blk_i  (ld_blk_i),
        .wr_addr_i (ld_addr_i),
        .wr_data_i (ld_data_i),
        .size_en_i (ld_size_en_i && ld_ok_s),
        .size_i    (ld_size_i),
        .rd_blk_i  (blk_q),
        .rd_addr_i (rd_addr_s),
        .rd_data_o (rd_data_s),
        .sizes_o   (sizes_s)
    );

    assign cnt_inc_s = cnt_q + CNT_W'(1);

    // Read address for the word to load on the next handshake:
    // word 0 when leaving the header, counter+1 while in the payload
    always_comb begin
        rd_addr_s = {ADDR_W{1'b0}};
        if ((state_q == ST_PAY) && (cnt_inc_s < CNT_W'(DEPTH))) begin
            rd_addr_s = ADDR_W'(cnt_inc_s);
        end else begin
            rd_addr_s = {ADDR_W{1'b0}};
        end
    end

    // Length of the block currently being sent
    always_comb begin
        cur_size_s = sizes_s[0];
        if ((NUM_BLOCKS > 1) && (blk_q == BLK_W'(1))) begin
            cur_size_s = sizes_s[NUM_BLOCKS-1];
        end else begin
            cur_size_s = sizes_s[0];
        end
    end

    assign last_word_s = (cnt_q == (cur_size_s - CNT_W'(1)));

    // Next-state, counter and output-register logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (flush_i) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                valid_d = 1'b0;
                cnt_d   = {CNT_W{1'b0}};
                blk_d   = {BLK_W{1'b0}};
                if (!flush_i) begin
                    state_d = ST_HDR;
                    data_d  = hdr_word(sizes_s[0]);
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_HDR, ST_PAY: begin
                if (flush_i) begin
                    state_d = ST_ARMED;
                    valid_d = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    blk_d   = {BLK_W{1'b0}};
                end else if (strm.ready) begin
                    if ((state_q == ST_HDR) && (cur_size_s != {CNT_W{1'b0}})) begin
                        state_d = ST_PAY;
                        cnt_d   = {CNT_W{1'b0}};
                        data_d  = rd_data_s;
                    end else if ((state_q == ST_PAY) && !last_word_s) begin
                        cnt_d  = cnt_inc_s;
                        data_d = rd_data_s;
                    end else if (blk_q == LAST_BLK) begin
                        state_d = ST_FIN;
                        cnt_d   = {CNT_W{1'b0}};
                        valid_d = 1'b0;
                    end else begin
                        // With at most two blocks the next block is the last one
                        state_d = ST_HDR;
                        cnt_d   = {CNT_W{1'b0}};
                        blk_d   = blk_q + BLK_W'(1);
                        data_d  = hdr_word(sizes_s[NUM_BLOCKS-1]);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_FIN: begin
                valid_d = 1'b0;
                if (flush_i) begin
                    state_d = ST_ARMED;
                    cnt_d   = {CNT_W{1'b0}};
                    blk_d   = {BLK_W{1'b0}};
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                valid_d = 1'b0;
                if (flush_i) begin
                    state_d = ST_ARMED;
                    done_d  = 1'b0;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            blk_q   <= {BLK_W{1'b0}};
            data_q  <= {DATA_WIDTH{1'b0}};
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign strm.data  = data_q;
    assign strm.valid = valid_q;
    assign strm.done  = done_q;

endmodule

// File: tb/tb_glb_write.sv
// Directed bench for glb_write: a one-block and a two-block instance share
// the load/flush/ready stimulus; each has its own expected-word scoreboard.
module tb_glb_write;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        ld_en;
    logic        ld_blk;
    logic [9:0]  ld_addr;
    logic [15:0] ld_data;
    logic        ld_size_en;
    logic [15:0] ld_size;
    logic        ready;

    int errors = 0;
    int checks = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    logic        pend_a, pend_b;
    logic [15:0] hold_a, hold_b;

    glb_write_if #(.DATA_WIDTH(16)) if_a ();
    glb_write_if #(.DATA_WIDTH(16)) if_b ();
    assign if_a.ready = ready;
    assign if_b.ready = ready;

    glb_write #(.NUM_BLOCKS(1), .DEPTH(1024), .DATA_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .flush_i(flush), .ld_en_i(ld_en), .ld_blk_i(ld_blk),
        .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_size_en_i(ld_size_en),
        .ld_size_i(ld_size), .strm(if_a.master)
    );

    glb_write #(.NUM_BLOCKS(2), .DEPTH(1024), .DATA_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .flush_i(flush), .ld_en_i(ld_en), .ld_blk_i(ld_blk),
        .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_size_en_i(ld_size_en),
        .ld_size_i(ld_size), .strm(if_b.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream monitors: pop the scoreboard on each handshake, check hold on stalls
    always @(negedge clk) begin
        if (pend_a) begin
            chk("hold_valid_a", 32'(if_a.valid), 32'd1);
            chk("hold_data_a", 32'(if_a.data), 32'(hold_a));
        end
        pend_a <= 1'b0;
        if (!rst && if_a.valid && !flush) begin
            if (ready) begin
                chk("avail_a", 32'(qa.size() != 0), 32'd1);
                if (qa.size() != 0) chk("stream_a", 32'(if_a.data), 32'(qa.pop_front()));
            end else begin
                pend_a <= 1'b1;
                hold_a <= if_a.data;
            end
        end
    end

    always @(negedge clk) begin
        if (pend_b) begin
            chk("hold_valid_b", 32'(if_b.valid), 32'd1);
            chk("hold_data_b", 32'(if_b.data), 32'(hold_b));
        end
        pend_b <= 1'b0;
        if (!rst && if_b.valid && !flush) begin
            if (ready) begin
                chk("avail_b", 32'(qb.size() != 0), 32'd1);
                if (qb.size() != 0) chk("stream_b", 32'(if_b.data), 32'(qb.pop_front()));
            end else begin
                pend_b <= 1'b1;
                hold_b <= if_b.data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld_word(input logic b, input logic [9:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_blk = b; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic ld_sz(input logic b, input logic [15:0] s);
        ld_size_en = 1'b1; ld_blk = b; ld_size = s;
        tick();
        ld_size_en = 1'b0;
    endtask

    task automatic push_both(input logic [15:0] w);
        qa.push_back(w);
        qb.push_back(w);
    endtask

    // High-then-low flush; returns just after the edge that presents the header
    task automatic flush_pulse();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (if_a.done && if_b.done) break;
            tick();
        end
        chk(tag, {30'd0, if_a.done, if_b.done}, 32'd3);
    endtask

    initial begin
        logic [3:0] pat;
        pat = 4'b1001;
        pend_a = 1'b0; pend_b = 1'b0;
        rst = 1'b1; flush = 1'b0; ld_en = 1'b0; ld_blk = 1'b0; ld_addr = 10'd0;
        ld_data = 16'd0; ld_size_en = 1'b0; ld_size = 16'd0; ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid_a", 32'(if_a.valid), 32'd0);
        chk("rst_done_a", 32'(if_a.done), 32'd0);
        chk("rst_data_a", 32'(if_a.data), 32'd0);
        chk("rst_valid_b", 32'(if_b.valid), 32'd0);
        chk("rst_done_b", 32'(if_b.done), 32'd0);
        chk("rst_data_b", 32'(if_b.data), 32'd0);
        rst = 1'b0;
        tick();

        // 1: block0 = 4 words, ready held high, exact timing on the one-block unit
        ld_sz(1'b0, 16'd4);
        for (int i = 0; i < 4; i++) ld_word(1'b0, 10'(i), 16'hA000 + 16'(i));
        push_both(16'h0004);
        for (int i = 0; i < 4; i++) push_both(16'hA000 + 16'(i));
        qb.push_back(16'h0000);
        flush_pulse();
        chk("t1_hdr_valid", 32'(if_a.valid), 32'd1);
        chk("t1_hdr_data", 32'(if_a.data), 32'h0004);
        repeat (4) tick();
        chk("t1_last_word", 32'(if_a.data), 32'hA003);
        tick();
        chk("t1_fin_valid", 32'(if_a.valid), 32'd0);
        tick();
        chk("t1_done_early", 32'(if_a.done), 32'd0);
        tick();
        chk("t1_done_lat", 32'(if_a.done), 32'd1);
        wait_done("t1_done");

        // 2: same buffers, ready toggling 1,0,0,1
        push_both(16'h0004);
        for (int i = 0; i < 4; i++) push_both(16'hA000 + 16'(i));
        qb.push_back(16'h0000);
        flush_pulse();
        for (int i = 0; i < 200; i++) begin
            if (if_a.done && if_b.done) break;
            ready = pat[i % 4];
            tick();
        end
        ready = 1'b1;
        wait_done("t2_done");

        // 3: block0 empty, block1 two words (ignored by the one-block unit)
        ld_sz(1'b0, 16'd0);
        ld_sz(1'b1, 16'd2);
        ld_word(1'b1, 10'd0, 16'hB000);
        ld_word(1'b1, 10'd1, 16'hB001);
        qa.push_back(16'h0000);
        qb.push_back(16'h0000); qb.push_back(16'h0002);
        qb.push_back(16'hB000); qb.push_back(16'hB001);
        flush_pulse();
        wait_done("t3_done");

        // 4: full-depth block, length written as 2000 and clamped
        ld_sz(1'b0, 16'd2000);
        for (int i = 0; i < 1024; i++) ld_word(1'b0, 10'(i), 16'(i));
        push_both(16'h0400);
        for (int i = 0; i < 1024; i++) push_both(16'(i));
        qb.push_back(16'h0002); qb.push_back(16'hB000); qb.push_back(16'hB001);
        flush_pulse();
        chk("t4_hdr_clamp", 32'(if_a.data), 32'h0400);
        wait_done("t4_done");

        // 5: abort after three payload handshakes; write attempt while streaming
        ld_sz(1'b0, 16'd6);
        for (int i = 0; i < 6; i++) ld_word(1'b0, 10'(i), 16'hC000 + 16'(i));
        push_both(16'h0006);
        for (int i = 0; i < 3; i++) push_both(16'hC000 + 16'(i));
        flush_pulse();
        ld_en = 1'b1; ld_blk = 1'b0; ld_addr = 10'd0; ld_data = 16'hDEAD;
        tick();
        ld_en = 1'b0;
        repeat (3) tick();
        flush = 1'b1; ready = 1'b0;
        tick();
        chk("t5_abort_valid_a", 32'(if_a.valid), 32'd0);
        chk("t5_abort_valid_b", 32'(if_b.valid), 32'd0);
        chk("t5_abort_drain", 32'(qa.size() + qb.size()), 32'd0);
        push_both(16'h0006);
        for (int i = 0; i < 6; i++) push_both(16'hC000 + 16'(i));
        qb.push_back(16'h0002); qb.push_back(16'hB000); qb.push_back(16'hB001);
        flush = 1'b0; ready = 1'b1;
        tick();
        chk("t5_restart_hdr", 32'(if_a.data), 32'h0006);
        wait_done("t5_done");

        // 6: asynchronous reset in the middle of a payload
        ld_sz(1'b0, 16'd3);
        for (int i = 0; i < 3; i++) ld_word(1'b0, 10'(i), 16'hD000 + 16'(i));
        push_both(16'h0003);
        push_both(16'hD000);
        flush_pulse();
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid_a", 32'(if_a.valid), 32'd0);
        chk("t6_rst_data_a", 32'(if_a.data), 32'd0);
        chk("t6_rst_done_a", 32'(if_a.done), 32'd0);
        chk("t6_rst_valid_b", 32'(if_b.valid), 32'd0);
        chk("t6_rst_data_b", 32'(if_b.data), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_drain", 32'(qa.size() + qb.size()), 32'd0);
        qa.push_back(16'h0000);
        qb.push_back(16'h0000); qb.push_back(16'h0000);
        flush_pulse();
        chk("t6_hdr_zero", 32'(if_a.data), 32'h0000);
        wait_done("t6_done");

        repeat (2) tick();
        chk("final_empty_a", 32'(qa.size()), 32'd0);
        chk("final_empty_b", 32'(qb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/glb_write.md
Name: glb_write

Overview:
- Streaming source that feeds a CGRA input IO tile from the GLB side.
- Holds up to NUM_BLOCKS preloaded data blocks. After a flush pulse it transmits each block over a ready/valid link: one length header word, then the payload words.
- It is the transmit-side counterpart of the block-stream receiver used by the sparse memory-core tests. The same wire protocol applies: header word = payload length, then payload.

Parameters:
- NUM_BLOCKS, 1, number of blocks streamed per flush (1 or 2).
- DEPTH, 1024, payload words per block buffer.
- DATA_WIDTH, 16, word width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  stream start: a high-then-low sequence arms one transmission.
- ld_en  in  1  write one payload word into a block buffer.
- ld_blk  in  1  target block for ld_en and ld_size_en.
- ld_addr  in  $clog2(DEPTH)  payload word index.
- ld_data  in  DATA_WIDTH  payload word.
- ld_size_en  in  1  write the block length register.
- ld_size  in  DATA_WIDTH  block length in words.
- data  out  DATA_WIDTH  stream word.
- valid  out  1  data is valid.
- ready  in  1  downstream accepts.
- done  out  1  all blocks sent; holds until next flush or reset.

Behaviour:
- Reset (async, rst=1):
  - data=0, valid=0, done=0.
  - FSM to IDLE, word counter=0, block index=0.
  - Size registers reset to 0. Buffer contents are not reset.
- Loading:
  - ld_en/ld_size_en take effect in IDLE and DONE only. In any other state they are ignored.
  - ld_blk >= NUM_BLOCKS is ignored.
  - ld_size > DEPTH is clamped to DEPTH when written.
- FSM states:
  - IDLE: valid=0. On flush=1 go to ARMED.
  - ARMED: on flush=0 go to HDR (i.e. the flush falling edge). The header is presented the next cycle.
  - HDR: data=size[blk], valid=1.
    - On valid&&ready: counter=0.
    - If size[blk]==0, finish the block (next HDR, or FIN).
    - Otherwise go to PAY.
  - PAY: data=buf[blk][counter], valid=1.
    - On handshake: counter++.
    - After the last word (counter==size-1), finish the block: blk++ and go to HDR, or go to FIN if blk==NUM_BLOCKS-1.
  - FIN: valid=0 for one cycle, then DONE.
  - DONE: done=1, valid=0. On flush=1 clear done and go to ARMED (restream the same buffers).
- Handshake:
  - data/valid are registered.
  - The next word is loaded in the same cycle as the accepting handshake, so with ready held high one word transfers per cycle.
  - data is stable while valid=1 and ready=0 (AXI-style). valid never drops without a handshake, except on reset or flush.
- Latency:
  - Flush falling edge to first valid header: 1 cycle.
  - Block of N words with ready=1: N+1 transfer cycles.
  - Last handshake to done=1: 2 cycles.
- Flush mid-stream (flush=1 in HDR/PAY/FIN):
  - Abort: valid=0 next cycle, counter and blk cleared, go to ARMED.
  - Restart from block 0 header after flush falls.
- Boundary cases:
  - size==DEPTH: the last payload address is DEPTH-1, with no wrap.
  - The counter never exceeds size-1.
- Widths: the header carries the size zero-extended or truncated to DATA_WIDTH. The counter is $clog2(DEPTH+1) bits.

Decomposition:
- Package glb_write_pkg holds:
  - typedef enum for the FSM states (IDLE, ARMED, HDR, PAY, FIN, DONE).
  - localparams for the address and counter widths.
- Sub-module glb_write_buf holds the NUM_BLOCKS x DEPTH x DATA_WIDTH storage and the size registers.
  - One write port driven by the ld_* signals.
  - Combinational read port indexed by blk and counter.
- The top level contains the FSM, the counter and the output registers.

Test Plan:
- Load block0 size=4 with data A0..A3, NUM_BLOCKS=1, ready=1, pulse flush → stream 0004,A0,A1,A2,A3 on 5 consecutive cycles; done=1 two cycles after the last handshake.
- Same load with ready toggling 1,0,0,1,... → data held stable while ready=0; same 5-word sequence; no duplicates or drops.
- NUM_BLOCKS=2, block0 size=0 and block1 size=2 (B0,B1) → stream 0000,0002,B0,B1; then done.
- size=DEPTH (1024) with a ramp load → header 0400 then 0..1023 in order; ld_size=2000 also reads back as header 0400.
- Flush asserted after 3 payload handshakes → valid=0 next cycle; after flush falls the stream restarts at the block0 header. A ld_en attempted while streaming leaves the buffer unchanged.
- rst asserted mid-PAY (asynchronously, between clock edges) → valid/done/data go to 0 immediately; a subsequent flush sends header 0000, since sizes are reset.
